// File: rtl/dmem_timer_responder.sv
// dmem_timer_responder: memory-mapped 64-bit timer/compare peripheral that
// answers processor data-port requests after a fixed response latency and
// raises a level interrupt once mtime reaches mtimecmp.
module dmem_timer_responder #(
  parameter int unsigned RESP_LATENCY = 2,
  parameter int unsigned PRESCALE     = 1,
  parameter logic [63:0] MTIME_RESET  = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_sel,
  input  logic [31:0] ip_data_addr,
  input  logic        ip_data_wr,
  input  logic [3:0]  ip_data_mask,
  input  logic [31:0] ip_data_from_proc,
  input  logic        ip_data_rd,
  output logic        op_data_valid,
  output logic [31:0] op_data_from_dmem,
  output logic        op_irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0]  LAT_LOAD = 4'(RESP_LATENCY - 1);
  localparam logic [31:0] PRE_MAX  = 32'(PRESCALE - 1);

  // Byte-lane merge of write data into an existing 32-bit register value.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  mask);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_lat_cnt;
  logic [2:0]  r_addr;
  logic        r_wr;
  logic [3:0]  r_mask;
  logic [31:0] r_wdata;
  logic        r_valid;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_en;
  logic [31:0] r_pre_cnt;
  logic        r_irq;
  logic [31:0] w_rdata;

  // Address bits outside [4:2] are decoded by the SoC, not here.
  logic w_unused_addr;
  assign w_unused_addr = ^{ip_data_addr[31:5], ip_data_addr[1:0]};

  logic w_req;
  logic w_commit;
  logic w_tick;
  logic w_ge;
  logic w_mt_lo_wr;
  logic w_mt_hi_wr;

  assign w_req      = ip_sel & (ip_data_rd | ip_data_wr);
  assign w_commit   = (r_state == S_RESP) & r_wr;
  assign w_tick     = r_en & (r_pre_cnt == PRE_MAX);
  assign w_ge       = (r_mtime >= r_mtimecmp);
  assign w_mt_lo_wr = w_commit & (r_addr == 3'd0) & (r_mask != 4'd0);
  assign w_mt_hi_wr = w_commit & (r_addr == 3'd1) & (r_mask != 4'd0);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, answer once in RESP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (LAT_LOAD == 4'd0) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_WAIT;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt <= 4'd1) begin
          w_next_state = S_RESP;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Request capture at accept and latency countdown while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lat_cnt <= 4'd0;
      r_addr    <= 3'd0;
      r_wr      <= 1'b0;
      r_mask    <= 4'd0;
      r_wdata   <= 32'd0;
    end else if ((r_state == S_IDLE) && w_req) begin
      r_lat_cnt <= LAT_LOAD;
      r_addr    <= ip_data_addr[4:2];
      r_wr      <= ip_data_wr;
      r_mask    <= ip_data_mask;
      r_wdata   <= ip_data_from_proc;
    end else if (r_state == S_WAIT) begin
      r_lat_cnt <= r_lat_cnt - 4'd1;
    end
  end

  // Response strobe, high exactly for the RESP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_next_state == S_RESP);
    end
  end

  // Prescale counter, frozen while the timer is disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre_cnt <= 32'd0;
    end else if (r_en) begin
      r_pre_cnt <= w_tick ? 32'd0 : (r_pre_cnt + 32'd1);
    end
  end

  // mtime: a software write wins over (and suppresses) that cycle's increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtime <= MTIME_RESET;
    end else if (w_mt_lo_wr) begin
      r_mtime[31:0] <= f_merge(r_mtime[31:0], r_wdata, r_mask);
    end else if (w_mt_hi_wr) begin
      r_mtime[63:32] <= f_merge(r_mtime[63:32], r_wdata, r_mask);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // Compare value and enable bit, written when a write leaves RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_en       <= 1'b0;
    end else if (w_commit) begin
      case (r_addr)
        3'd2:    r_mtimecmp[31:0]  <= f_merge(r_mtimecmp[31:0], r_wdata, r_mask);
        3'd3:    r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], r_wdata, r_mask);
        3'd4:    r_en              <= r_mask[0] ? r_wdata[0] : r_en;
        default: r_en              <= r_en;
      endcase
    end
  end

  // Interrupt level, one cycle behind the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_en & w_ge;
    end
  end

  // Register read mux over the current register contents.
  always_comb begin
    w_rdata = 32'd0;
    case (r_addr)
      3'd0:    w_rdata = r_mtime[31:0];
      3'd1:    w_rdata = r_mtime[63:32];
      3'd2:    w_rdata = r_mtimecmp[31:0];
      3'd3:    w_rdata = r_mtimecmp[63:32];
      3'd4:    w_rdata = {31'd0, r_en};
      3'd5:    w_rdata = {31'd0, w_ge};
      default: w_rdata = 32'd0;
    endcase
  end

  assign op_data_valid     = r_valid;
  assign op_data_from_dmem = (r_valid && !r_wr) ? w_rdata : 32'd0;
  assign op_irq            = r_irq;

endmodule

// File: tb/tb_dmem_timer_responder.sv
// Scoreboard bench for dmem_timer_responder: randomized register traffic
// checked against an arithmetic model of mtime (base + elapsed edges).
module tb_dmem_timer_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ip_sel;
  logic [31:0] ip_data_addr;
  logic        ip_data_wr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_from_proc;
  logic        ip_data_rd;
  logic        op_data_valid;
  logic [31:0] op_data_from_dmem;
  logic        op_irq;

  dmem_timer_responder #(.RESP_LATENCY(LAT), .PRESCALE(1), .MTIME_RESET(64'd0)) dut (
    .clk(clk), .reset(reset), .ip_sel(ip_sel), .ip_data_addr(ip_data_addr),
    .ip_data_wr(ip_data_wr), .ip_data_mask(ip_data_mask),
    .ip_data_from_proc(ip_data_from_proc), .ip_data_rd(ip_data_rd),
    .op_data_valid(op_data_valid), .op_data_from_dmem(op_data_from_dmem),
    .op_irq(op_irq)
  );

  always #5 clk = ~clk;

  // Edge counter: value seen at a negedge is the number of the preceding posedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [31:0] data;
    bit          chk_data;
    bit          irq;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;
  bit   g_in_resp = 1'b0;

  // Reference model: mtime(k) = base + (k - base_edge) while enabled.
  logic [63:0] m_base;
  int          m_base_edge;
  bit          m_en;
  logic [63:0] m_cmp;

  function automatic logic [63:0] mt_at(input int k);
    if (m_en) return m_base + 64'(k - m_base_edge);
    return m_base;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_base      = 64'd0;
    m_base_edge = cyc;
    m_en        = 1'b0;
    m_cmp       = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: every valid strobe must match the oldest expected response.
  always @(negedge clk) begin
    if (op_data_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_valid: got valid=1 expected none (edge %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("resp_edge", 64'(cyc), 64'(mon_e.edge_n));
        if (mon_e.chk_data) check("rdata", {32'd0, op_data_from_dmem}, {32'd0, mon_e.data});
        check("resp_irq", {63'd0, op_irq}, {63'd0, mon_e.irq});
      end
    end
  end

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      ip_sel       = 1'b0;
      ip_data_rd   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ip_data_wr   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ip_data_addr = $urandom;
      @(negedge clk);
    end
    g_in_resp = 1'b0;
  endtask

  // One transaction: predict the response, drive, wait for valid, update model.
  task automatic xact(input logic [2:0] a, input bit wr, input bit rd,
                      input logic [3:0] mask, input logic [31:0] wd);
    int          acc, e_edge, c_edge;
    exp_t        x;
    logic [63:0] mt;
    logic [31:0] d;
    bit          done, scr;
    acc    = cyc + (g_in_resp ? 2 : 1);
    e_edge = acc + LAT - 1;
    mt     = mt_at(e_edge);
    d      = 32'd0;
    if (!wr) begin
      case (a)
        3'd0:    d = mt[31:0];
        3'd1:    d = mt[63:32];
        3'd2:    d = m_cmp[31:0];
        3'd3:    d = m_cmp[63:32];
        3'd4:    d = {31'd0, m_en};
        3'd5:    d = {31'd0, mt >= m_cmp};
        default: d = 32'd0;
      endcase
    end
    x.edge_n   = e_edge;
    x.data     = d;
    x.chk_data = rd;
    x.irq      = m_en && (mt_at(e_edge - 1) >= m_cmp);
    sb.push_back(x);
    ip_sel            = 1'b1;
    ip_data_addr      = {27'($urandom), a, 2'($urandom)};
    ip_data_wr        = wr;
    ip_data_rd        = rd;
    ip_data_mask      = mask;
    ip_data_from_proc = wd;
    done = 1'b0;
    scr  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (op_data_valid) done = 1'b1;
      else if (cyc >= acc && !scr) begin
        scr               = 1'b1;
        ip_data_addr      = $urandom;
        ip_data_mask      = 4'($urandom);
        ip_data_from_proc = $urandom;
      end
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("FAIL resp_timeout: got no valid expected edge %0d", e_edge);
    end
    if (wr) begin
      c_edge = cyc + 1;
      case (a)
        3'd0: if (mask != 4'd0) begin
          mt = mt_at(c_edge - 1);
          m_base = {mt[63:32], lane_merge(mt[31:0], wd, mask)};
          m_base_edge = c_edge;
        end
        3'd1: if (mask != 4'd0) begin
          mt = mt_at(c_edge - 1);
          m_base = {lane_merge(mt[63:32], wd, mask), mt[31:0]};
          m_base_edge = c_edge;
        end
        3'd2: m_cmp[31:0]  = lane_merge(m_cmp[31:0], wd, mask);
        3'd3: m_cmp[63:32] = lane_merge(m_cmp[63:32], wd, mask);
        3'd4: if (mask[0]) begin
          m_base = mt_at(c_edge);
          m_base_edge = c_edge;
          m_en = wd[0];
        end
        default: ;
      endcase
    end
    g_in_resp = 1'b1;
  endtask

  initial begin
    int c_en, c2, a, op;
    logic [31:0] wd;
    reset = 1'b0;
    ip_sel = 1'b0; ip_data_addr = 32'd0; ip_data_wr = 1'b0; ip_data_mask = 4'd0;
    ip_data_from_proc = 32'd0; ip_data_rd = 1'b0;
    model_reset();
    // Reset state held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_valid", {63'd0, op_data_valid}, 64'd0);
      check("rst_irq", {63'd0, op_irq}, 64'd0);
      check("rst_rdata", {32'd0, op_data_from_dmem}, 64'd0);
    end
    reset = 1'b1;
    model_reset();
    xact(3'd0, 1'b0, 1'b1, 4'h0, 32'd0);
    xact(3'd3, 1'b0, 1'b1, 4'h0, 32'd0);
    // Latency with idle start, then back-to-back.
    idle(1, 1'b0);
    xact(3'd4, 1'b0, 1'b1, 4'h0, 32'd0);
    xact(3'd4, 1'b0, 1'b1, 4'h0, 32'd0);
    // Masked write.
    xact(3'd2, 1'b1, 1'b0, 4'b0101, 32'hAABB_CCDD);
    xact(3'd2, 1'b0, 1'b1, 4'h0, 32'd0);
    // Carry from LO into HI.
    xact(3'd0, 1'b1, 1'b0, 4'hF, 32'hFFFF_FFFF);
    xact(3'd1, 1'b1, 1'b0, 4'hF, 32'd0);
    xact(3'd4, 1'b1, 1'b0, 4'h1, 32'd1);
    xact(3'd1, 1'b0, 1'b1, 4'h0, 32'd0);
    xact(3'd0, 1'b0, 1'b1, 4'h0, 32'd0);
    // Interrupt rise and drop.
    xact(3'd4, 1'b1, 1'b0, 4'h1, 32'd0);
    xact(3'd3, 1'b1, 1'b0, 4'hF, 32'd0);
    xact(3'd2, 1'b1, 1'b0, 4'hF, 32'd10);
    xact(3'd0, 1'b1, 1'b0, 4'hF, 32'd0);
    xact(3'd1, 1'b1, 1'b0, 4'hF, 32'd0);
    xact(3'd4, 1'b1, 1'b0, 4'h1, 32'd1);
    c_en = cyc + 1;
    ip_sel = 1'b0; ip_data_rd = 1'b0; ip_data_wr = 1'b0;
    while (cyc < c_en + 13) begin
      @(negedge clk);
      check("irq_rise", {63'd0, op_irq}, {63'd0, (cyc >= c_en + 11)});
    end
    g_in_resp = 1'b0;
    xact(3'd2, 1'b1, 1'b0, 4'hF, 32'd100);
    c2 = cyc + 1;
    ip_sel = 1'b0; ip_data_rd = 1'b0; ip_data_wr = 1'b0;
    while (cyc < c2 + 1) begin
      @(negedge clk);
      check("irq_drop", {63'd0, op_irq}, {63'd0, (cyc == c2)});
    end
    g_in_resp = 1'b0;
    xact(3'd5, 1'b0, 1'b1, 4'h0, 32'd0);
    // Reset during WAIT of a write drops it.
    idle(1, 1'b0);
    ip_sel = 1'b1; ip_data_addr = 32'h0000_0008; ip_data_wr = 1'b1; ip_data_rd = 1'b0;
    ip_data_mask = 4'hF; ip_data_from_proc = 32'h1234_5678;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ip_sel = 1'b0; ip_data_wr = 1'b0;
    #1;
    check("abort_valid", {63'd0, op_data_valid}, 64'd0);
    @(negedge clk);
    check("abort_valid2", {63'd0, op_data_valid}, 64'd0);
    reset = 1'b1;
    model_reset();
    idle(2, 1'b0);
    check("abort_irq", {63'd0, op_irq}, 64'd0);
    xact(3'd2, 1'b0, 1'b1, 4'h0, 32'd0);
    xact(3'd0, 1'b0, 1'b1, 4'h0, 32'd0);
    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4), 1'b1);
      a  = $urandom_range(0, 7);
      op = $urandom_range(0, 3);
      case (a)
        0, 2:    wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 80)) : $urandom;
        1, 3:    wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
        4:       wd = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0;
        default: wd = $urandom;
      endcase
      xact(3'(a), (op >= 2), (op != 2), 4'($urandom), wd);
    end
    idle(LAT + 3, 1'b0);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
